// File: rtl/writeback_pipe.sv
`default_nettype none
// ============================================================================
// writeback_pipe : dual (even/odd) result shift pipes with register writeback
//                  and newest-producer operand forwarding.
// Optional build macro: WB_FORWARD_EN (forward select; otherwise stall-only).
// Revision: 1.0
// ============================================================================
module writeback_pipe #(
  parameter int DEPTH   = 7,
  parameter int LAT_MIN = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         even_valid,
  input  logic [6:0]   even_rt,
  input  logic [127:0] even_result,
  input  logic [2:0]   even_lat,
  input  logic         odd_valid,
  input  logic [6:0]   odd_rt,
  input  logic [127:0] odd_result,
  input  logic [2:0]   odd_lat,
  input  logic [6:0]   fwd_addr0,
  input  logic [6:0]   fwd_addr1,
  input  logic [6:0]   fwd_addr2,
  input  logic [6:0]   fwd_addr3,
  input  logic [6:0]   fwd_addr4,
  input  logic [6:0]   fwd_addr5,
  output logic         wb1_en,
  output logic [6:0]   wb1_rt,
  output logic [127:0] wb1_data,
  output logic         wb2_en,
  output logic [6:0]   wb2_rt,
  output logic [127:0] wb2_data,
  output logic [5:0]   fwd_hit,
  output logic [127:0] fwd_data0,
  output logic [127:0] fwd_data1,
  output logic [127:0] fwd_data2,
  output logic [127:0] fwd_data3,
  output logic [127:0] fwd_data4,
  output logic [127:0] fwd_data5,
  output logic [5:0]   fwd_pending
);

  localparam int c_num_src = 6;

  function automatic logic [2:0] f_clamp_lat(input logic [2:0] lat);
    logic [2:0] v;
    if ({29'd0, lat} < 32'(LAT_MIN))
      v = 3'(LAT_MIN);
    else if ({29'd0, lat} > 32'(DEPTH))
      v = 3'(DEPTH);
    else
      v = lat;
    return v;
  endfunction

  logic [2:0] w_ev_lat_c;
  logic [2:0] w_od_lat_c;
  assign w_ev_lat_c = f_clamp_lat(even_lat);
  assign w_od_lat_c = f_clamp_lat(odd_lat);

  // Stage s of each pipe lives at index s (1..DEPTH); stage DEPTH drives writeback.
  logic [DEPTH:1] r_ev_vld;
  logic [DEPTH:1] r_od_vld;
  logic [6:0]     r_ev_rt   [1:DEPTH];
  logic [6:0]     r_od_rt   [1:DEPTH];
  logic [127:0]   r_ev_data [1:DEPTH];
  logic [127:0]   r_od_data [1:DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ev_vld <= '0;
      r_od_vld <= '0;
    end else if (flush) begin
      r_ev_vld <= '0;
      r_od_vld <= '0;
    end else begin
      r_ev_vld <= {r_ev_vld[DEPTH-1:1], even_valid};
      r_od_vld <= {r_od_vld[DEPTH-1:1], odd_valid};
    end
  end

  // Payload is only meaningful alongside its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    r_ev_rt[1]   <= even_rt;
    r_od_rt[1]   <= odd_rt;
    r_ev_data[1] <= even_result;
    r_od_data[1] <= odd_result;
    for (int s = 2; s <= DEPTH; s++) begin
      r_ev_rt[s]   <= r_ev_rt[s-1];
      r_od_rt[s]   <= r_od_rt[s-1];
      r_ev_data[s] <= r_ev_data[s-1];
      r_od_data[s] <= r_od_data[s-1];
    end
  end

  assign wb1_en   = r_ev_vld[DEPTH];
  assign wb1_rt   = wb1_en ? r_ev_rt[DEPTH]   : '0;
  assign wb1_data = wb1_en ? r_ev_data[DEPTH] : '0;
  assign wb2_en   = r_od_vld[DEPTH];
  assign wb2_rt   = wb2_en ? r_od_rt[DEPTH]   : '0;
  assign wb2_data = wb2_en ? r_od_data[DEPTH] : '0;

  logic [6:0] w_addr [c_num_src];
  assign w_addr[0] = fwd_addr0;
  assign w_addr[1] = fwd_addr1;
  assign w_addr[2] = fwd_addr2;
  assign w_addr[3] = fwd_addr3;
  assign w_addr[4] = fwd_addr4;
  assign w_addr[5] = fwd_addr5;

  logic [DEPTH:1] w_ev_match [c_num_src];
  logic [DEPTH:1] w_od_match [c_num_src];

  always_comb begin
    for (int k = 0; k < c_num_src; k++) begin
      w_ev_match[k] = '0;
      w_od_match[k] = '0;
      for (int s = 1; s <= DEPTH; s++) begin
        w_ev_match[k][s] = r_ev_vld[s] && (r_ev_rt[s] == w_addr[k]);
        w_od_match[k][s] = r_od_vld[s] && (r_od_rt[s] == w_addr[k]);
      end
    end
  end

  logic [127:0] w_fdata [c_num_src];

`ifdef WB_FORWARD_EN
  logic [2:0] r_ev_lat [1:DEPTH];
  logic [2:0] r_od_lat [1:DEPTH];

  always_ff @(posedge clk) begin
    r_ev_lat[1] <= w_ev_lat_c;
    r_od_lat[1] <= w_od_lat_c;
    for (int s = 2; s <= DEPTH; s++) begin
      r_ev_lat[s] <= r_ev_lat[s-1];
      r_od_lat[s] <= r_od_lat[s-1];
    end
  end

  logic [DEPTH:1] w_ev_rdy;
  logic [DEPTH:1] w_od_rdy;
  for (genvar s = 1; s <= DEPTH; s++) begin : g_rdy
    assign w_ev_rdy[s] = r_ev_vld[s] && ({29'd0, r_ev_lat[s]} <= 32'(s));
    assign w_od_rdy[s] = r_od_vld[s] && ({29'd0, r_od_lat[s]} <= 32'(s));
  end

  logic [c_num_src-1:0] w_sel_found;
  logic [c_num_src-1:0] w_sel_rdy;
  logic [127:0]         w_sel_data [c_num_src];

  // Scan oldest to newest so the last match wins: lowest stage, odd over even.
  always_comb begin
    for (int k = 0; k < c_num_src; k++) begin
      w_sel_found[k] = 1'b0;
      w_sel_rdy[k]   = 1'b0;
      w_sel_data[k]  = '0;
      for (int s = DEPTH; s >= 1; s--) begin
        if (w_ev_match[k][s]) begin
          w_sel_found[k] = 1'b1;
          w_sel_rdy[k]   = w_ev_rdy[s];
          w_sel_data[k]  = r_ev_data[s];
        end
        if (w_od_match[k][s]) begin
          w_sel_found[k] = 1'b1;
          w_sel_rdy[k]   = w_od_rdy[s];
          w_sel_data[k]  = r_od_data[s];
        end
      end
    end
  end

  for (genvar k = 0; k < c_num_src; k++) begin : g_fwd
    assign fwd_hit[k]     = w_sel_found[k] & w_sel_rdy[k];
    assign fwd_pending[k] = w_sel_found[k] & ~w_sel_rdy[k];
    assign w_fdata[k]     = fwd_hit[k] ? w_sel_data[k] : '0;
  end
`else
  // Without forwarding, any in-flight producer of a source simply stalls it.
  logic w_unused_lat;
  assign w_unused_lat = ^{w_ev_lat_c, w_od_lat_c};

  assign fwd_hit = '0;
  for (genvar k = 0; k < c_num_src; k++) begin : g_fwd
    assign fwd_pending[k] = |{w_ev_match[k], w_od_match[k]};
    assign w_fdata[k]     = '0;
  end
`endif

  assign fwd_data0 = w_fdata[0];
  assign fwd_data1 = w_fdata[1];
  assign fwd_data2 = w_fdata[2];
  assign fwd_data3 = w_fdata[3];
  assign fwd_data4 = w_fdata[4];
  assign fwd_data5 = w_fdata[5];

endmodule
`default_nettype wire

// File: tb/tb_writeback_pipe.sv
`default_nettype none
// ============================================================================
// tb_writeback_pipe : scoreboard bench; directed scenarios then random traffic
//                     against a list-of-results reference model.
// Revision: 1.0
// ============================================================================
module tb_writeback_pipe;
  localparam int DEPTH   = 7;
  localparam int LAT_MIN = 2;
  localparam int c_big   = 32'h7fff_ffff;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         even_valid, odd_valid;
  logic [6:0]   even_rt, odd_rt;
  logic [127:0] even_result, odd_result;
  logic [2:0]   even_lat, odd_lat;
  logic [6:0]   fa [6];
  logic [6:0]   nx_fa [6];
  logic         wb1_en, wb2_en;
  logic [6:0]   wb1_rt, wb2_rt;
  logic [127:0] wb1_data, wb2_data;
  logic [5:0]   fwd_hit, fwd_pending;
  logic [127:0] fwd_data0, fwd_data1, fwd_data2, fwd_data3, fwd_data4, fwd_data5;
  logic [127:0] fd [6];

  assign fd[0] = fwd_data0;
  assign fd[1] = fwd_data1;
  assign fd[2] = fwd_data2;
  assign fd[3] = fwd_data3;
  assign fd[4] = fwd_data4;
  assign fd[5] = fwd_data5;

  writeback_pipe #(.DEPTH(DEPTH), .LAT_MIN(LAT_MIN)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .even_valid(even_valid), .even_rt(even_rt), .even_result(even_result), .even_lat(even_lat),
    .odd_valid(odd_valid), .odd_rt(odd_rt), .odd_result(odd_result), .odd_lat(odd_lat),
    .fwd_addr0(fa[0]), .fwd_addr1(fa[1]), .fwd_addr2(fa[2]),
    .fwd_addr3(fa[3]), .fwd_addr4(fa[4]), .fwd_addr5(fa[5]),
    .wb1_en(wb1_en), .wb1_rt(wb1_rt), .wb1_data(wb1_data),
    .wb2_en(wb2_en), .wb2_rt(wb2_rt), .wb2_data(wb2_data),
    .fwd_hit(fwd_hit),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .fwd_data3(fwd_data3), .fwd_data4(fwd_data4), .fwd_data5(fwd_data5),
    .fwd_pending(fwd_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A result issued in cycle I sits in stage (C-I) during cycle C and is
  // visible while that stage is 1..DEPTH and C is before its kill cycle.
  typedef struct {
    int           pipe;
    logic [6:0]   rt;
    logic [127:0] data;
    int           lat;
    int           issue;
    int           dead;
  } rec_t;
  typedef struct {
    logic [6:0]   rt;
    logic [127:0] data;
    int           due;
    int           dead;
  } wbe_t;

  rec_t q_fly[$];
  wbe_t exp_wb[2][$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string name, input int idx,
                     input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s[%0d] cycle %0d: got %h want %h", name, idx, cyc, act, exp);
  endtask

  function automatic int clamp(input int l);
    if (l < LAT_MIN) return LAT_MIN;
    if (l > DEPTH) return DEPTH;
    return l;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic kill_all(input int from);
    foreach (q_fly[i]) if (q_fly[i].dead > from) q_fly[i].dead = from;
    for (int p = 0; p < 2; p++)
      foreach (exp_wb[p][i]) if (exp_wb[p][i].dead > from) exp_wb[p][i].dead = from;
  endtask

  task automatic add_res(input int p, input logic [6:0] rt, input logic [127:0] d,
                         input logic [2:0] l);
    rec_t r;
    wbe_t w;
    r.pipe = p; r.rt = rt; r.data = d; r.lat = clamp(int'(l));
    r.issue = cyc; r.dead = c_big;
    q_fly.push_back(r);
    w.rt = rt; w.data = d; w.due = cyc + DEPTH; w.dead = c_big;
    exp_wb[p].push_back(w);
  endtask

  // One cycle of stimulus: pins change 1ns after the edge that opens the cycle.
  task automatic issue(input bit ev, input logic [6:0] ert, input logic [127:0] ed,
                       input logic [2:0] el, input bit ov, input logic [6:0] ort,
                       input logic [127:0] od, input logic [2:0] ol,
                       input bit fl, input bit rn);
    @(posedge clk);
    #1;
    even_valid = ev; even_rt = ert; even_result = ed; even_lat = el;
    odd_valid  = ov; odd_rt  = ort; odd_result  = od; odd_lat  = ol;
    flush = fl; reset_n = rn;
    for (int k = 0; k < 6; k++) fa[k] = nx_fa[k];
    for (int i = q_fly.size() - 1; i >= 0; i--)
      if (cyc - q_fly[i].issue > DEPTH + 2) q_fly.delete(i);
    if (!rn) kill_all(cyc);
    else if (fl) kill_all(cyc + 1);
    else begin
      if (ev) add_res(0, ert, ed, el);
      if (ov) add_res(1, ort, od, ol);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) issue(0, 7'd0, '0, 3'd0, 0, 7'd0, '0, 3'd0, 0, 1);
  endtask

  task automatic set_fa(input logic [6:0] a);
    for (int k = 0; k < 6; k++) nx_fa[k] = a;
  endtask

  // Monitor: pops expected writebacks when due and checks forwarding each cycle.
  logic         m_en;
  logic [6:0]   m_rt;
  logic [127:0] m_d;
  wbe_t         m_e;
  bit           m_found, m_rdy, e_hit, e_pend;
  int           m_best, m_st;
  logic [127:0] m_bdata, e_data;

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      m_en = (p == 0) ? wb1_en   : wb2_en;
      m_rt = (p == 0) ? wb1_rt   : wb2_rt;
      m_d  = (p == 0) ? wb1_data : wb2_data;
      while (exp_wb[p].size() > 0 && exp_wb[p][0].due >= exp_wb[p][0].dead)
        void'(exp_wb[p].pop_front());
      if (exp_wb[p].size() > 0 && exp_wb[p][0].due == cyc) begin
        m_e = exp_wb[p].pop_front();
        chk(m_en && m_rt == m_e.rt && m_d == m_e.data, "wb", p + 1,
            {m_en, m_rt, m_d}, {1'b1, m_e.rt, m_e.data});
      end else begin
        chk(!m_en && m_rt == 7'd0 && m_d == 128'd0, "wb_idle", p + 1,
            {m_en, m_rt, m_d}, 136'd0);
      end
    end
    for (int k = 0; k < 6; k++) begin
      m_found = 0; m_rdy = 0; m_best = 0; m_bdata = '0;
      foreach (q_fly[i]) begin
        m_st = cyc - q_fly[i].issue;
        if (m_st >= 1 && m_st <= DEPTH && cyc < q_fly[i].dead && q_fly[i].rt == fa[k])
          if (!m_found || m_st < m_best || (m_st == m_best && q_fly[i].pipe == 1)) begin
            m_found = 1; m_best = m_st; m_bdata = q_fly[i].data;
            m_rdy = (m_st >= q_fly[i].lat);
          end
      end
`ifdef WB_FORWARD_EN
      e_hit  = m_found && m_rdy;
      e_pend = m_found && !m_rdy;
      e_data = e_hit ? m_bdata : '0;
`else
      e_hit  = 0;
      e_pend = m_found;
      e_data = '0;
`endif
      chk(fwd_hit[k] == e_hit && fwd_pending[k] == e_pend && fd[k] == e_data, "fwd", k,
          {6'd0, fwd_hit[k], fwd_pending[k], fd[k]}, {6'd0, e_hit, e_pend, e_data});
    end
  end

  logic [127:0] c_a5;
  int           rem;

  initial begin
    reset_n = 0; flush = 0;
    even_valid = 0; even_rt = '0; even_result = '0; even_lat = '0;
    odd_valid = 0; odd_rt = '0; odd_result = '0; odd_lat = '0;
    for (int k = 0; k < 6; k++) begin fa[k] = 7'h70; nx_fa[k] = 7'h70; end
    c_a5 = {16{8'hA5}};

    repeat (3) issue(0, 7'd0, '0, 3'd0, 0, 7'd0, '0, 3'd0, 0, 0);
    idle(2);

    // Single even result forwarded from stage 2 and written in stage DEPTH.
    nx_fa[0] = 7'd5;
    issue(1, 7'd5, c_a5, 3'd2, 0, 7'd0, '0, 3'd0, 0, 1);
    idle(10);

    // Newer not-ready producer masks an older ready one.
    set_fa(7'h70); nx_fa[3] = 7'd9;
    issue(1, 7'd9, 128'd1, 3'd2, 0, 7'd0, '0, 3'd0, 0, 1);
    issue(0, 7'd0, '0, 3'd0, 1, 7'd9, 128'd2, 3'd6, 0, 1);
    idle(10);

    // Same rt on both pipes in one cycle.
    set_fa(7'd12);
    issue(1, 7'd12, 128'd3, 3'd2, 1, 7'd12, 128'd4, 3'd2, 0, 1);
    idle(10);

    // Latency clamping at both ends.
    set_fa(7'd20); nx_fa[1] = 7'd21;
    issue(1, 7'd20, 128'h77, 3'd0, 1, 7'd21, 128'h88, 3'd7, 0, 1);
    issue(1, 7'd21, 128'h99, 3'd1, 0, 7'd0, '0, 3'd0, 0, 1);
    idle(10);

    // Flush with three results in flight; inputs in the flush cycle are dropped.
    set_fa(7'd30); nx_fa[1] = 7'd31; nx_fa[2] = 7'd32;
    issue(1, 7'd30, 128'h30, 3'd2, 0, 7'd0, '0, 3'd0, 0, 1);
    issue(0, 7'd0, '0, 3'd0, 1, 7'd31, 128'h31, 3'd3, 0, 1);
    issue(1, 7'd32, 128'h32, 3'd2, 0, 7'd0, '0, 3'd0, 0, 1);
    issue(1, 7'd30, 128'h33, 3'd2, 1, 7'd31, 128'h34, 3'd2, 1, 1);
    idle(10);

    // Asynchronous reset mid-flight.
    issue(1, 7'd30, 128'h40, 3'd2, 0, 7'd0, '0, 3'd0, 0, 1);
    issue(0, 7'd0, '0, 3'd0, 1, 7'd31, 128'h41, 3'd2, 0, 1);
    issue(1, 7'd32, 128'h42, 3'd4, 1, 7'd30, 128'h43, 3'd2, 0, 1);
    issue(1, 7'd31, 128'h44, 3'd2, 0, 7'd0, '0, 3'd0, 0, 1);
    issue(1, 7'd32, 128'h45, 3'd2, 0, 7'd0, '0, 3'd0, 0, 0);
    issue(0, 7'd0, '0, 3'd0, 0, 7'd0, '0, 3'd0, 0, 0);
    issue(1, 7'd30, 128'h46, 3'd2, 0, 7'd0, '0, 3'd0, 0, 1);
    idle(10);

    // Randomised traffic on a small register pool to force frequent matches.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 6; k++) nx_fa[k] = 7'($urandom_range(0, 7));
      issue($urandom_range(0, 99) < 60,
            ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7)),
            rnd128(), 3'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 60,
            ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7)),
            rnd128(), 3'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) != 0);
    end
    idle(DEPTH + 3);

    @(negedge clk);
    #1;
    rem = 0;
    for (int p = 0; p < 2; p++)
      foreach (exp_wb[p][i]) if (exp_wb[p][i].due < exp_wb[p][i].dead) rem++;
    chk(rem == 0, "wb_drain", 0, 136'(rem), 136'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
